// File: rtl/spi_ram_pkg.sv
// Shared constants, state type and configuration check for the SPI RAM endpoint.
package spi_ram_pkg;

  localparam logic [1:0] OP_WR = 2'b00;
  localparam logic [1:0] OP_RD = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OPCODE  = 3'd1,
    ST_ADDR    = 3'd2,
    ST_WR_DATA = 3'd3,
    ST_RD_TURN = 3'd4,
    ST_RD_DATA = 3'd5,
    ST_IGNORE  = 3'd6,
    ST_WAIT_SS = 3'd7
  } state_e;

  // A RAM may not hold more words than the wire address can reach.
  function automatic bit depth_ok(input int addr_w, input int depth);
    return (addr_w >= 1) && (addr_w < 31) && (depth >= 1) &&
           (longint'(depth) <= (longint'(1) << addr_w));
  endfunction

endpackage

// File: rtl/spi_ram_sp_mem.sv
// Single-port synchronous RAM, one-cycle read latency, array left unreset.
module spi_ram_sp_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write when enabled; read every cycle from the same address.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= din;
    dout <= mem_q[addr];
  end

endmodule

// File: rtl/spi_ram_burst_top.sv
// SPI slave (clk is the bit clock) fronting a single-port RAM with
// auto-incrementing, wrapping burst write and burst read.
module spi_ram_burst_top
  import spi_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic frame_err
);

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  if (!depth_ok(ADDR_W, DEPTH)) begin : g_bad_cfg
    $error("spi_ram_burst_top: DEPTH must be between 1 and 2**ADDR_W");
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   addr_sh_q, addr_sh_d;
  logic [DATA_W-1:0]   dat_sh_q, dat_sh_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                op_q, op_d;
  logic                rd_q, rd_d;
  logic                we_q, we_d;
  logic                miso_q, miso_d;
  logic                err_q, err_d;
  logic                ferr_q, ferr_d;
  logic [DATA_W-1:0]   rd_dout;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   wr_nxt;
  logic                mem_we;

  // Address pointer advance, wrapping at the last RAM word.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    if ({1'b0, p} == DEPTH_X - 1'b1) return '0;
    return p + 1'b1;
  endfunction

  assign addr_nxt  = ADDR_W'({addr_sh_q, MOSI});
  assign wr_nxt    = DATA_W'({dat_sh_q, MOSI});
  // A write pending on the same edge as reset is dropped.
  assign mem_we    = we_q & ~rst;
  assign MISO      = miso_q;
  assign frame_err = ferr_q;

  spi_ram_sp_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (ptr_q[MEM_AW-1:0]),
    .din  (wdata_q),
    .dout (rd_dout)
  );

  // Frame decoder: next state, shift registers, pointer and output bits.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    addr_sh_d = addr_sh_q;
    dat_sh_d  = dat_sh_q;
    wdata_d   = wdata_q;
    op_d      = op_q;
    rd_d      = rd_q;
    we_d      = 1'b0;
    miso_d    = 1'b0;
    err_d     = 1'b0;
    ferr_d    = err_q;  // errors surface one edge after detection
    // The completed word is written this cycle; move on to the next address.
    if (we_q) ptr_d = ptr_inc(ptr_q);
    if (SS_n) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      addr_sh_d = '0;
      dat_sh_d  = '0;
      op_d      = 1'b0;
      // Partial write word: dropped, flagged once.
      if (state_q == ST_WR_DATA && cnt_q != '0) err_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          op_d    = MOSI;
          cnt_d   = '0;
          state_d = ST_OPCODE;
        end
        ST_OPCODE: begin
          if ({op_q, MOSI} == OP_WR || {op_q, MOSI} == OP_RD) begin
            rd_d    = ({op_q, MOSI} == OP_RD);
            state_d = ST_ADDR;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IGNORE;
          end
        end
        ST_ADDR: begin
          addr_sh_d = addr_nxt;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ADDR_W - 1)) begin
            cnt_d = '0;
            if ({1'b0, addr_nxt} >= DEPTH_X) begin
              err_d   = 1'b1;
              state_d = ST_IGNORE;
            end else begin
              ptr_d   = addr_nxt;
              state_d = rd_q ? ST_RD_TURN : ST_WR_DATA;
            end
          end
        end
        ST_WR_DATA: begin
          dat_sh_d = wr_nxt;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d    = '0;
            wdata_d  = wr_nxt;
            we_d     = 1'b1;
            dat_sh_d = '0;
          end
        end
        // RAM is being read at ptr; MISO stays low.
        ST_RD_TURN: state_d = ST_RD_DATA;
        ST_RD_DATA: begin
          cnt_d = (cnt_q == CNT_W'(DATA_W - 1)) ? '0 : cnt_q + 1'b1;
          if (cnt_q == '0) begin
            // Word start: take the fetched word and advance so the next
            // word is already read by the time this one ends.
            miso_d   = rd_dout[DATA_W-1];
            dat_sh_d = rd_dout << 1;
            ptr_d    = ptr_inc(ptr_q);
          end else begin
            miso_d   = dat_sh_q[DATA_W-1];
            dat_sh_d = dat_sh_q << 1;
          end
        end
        default: ;  // IGNORE / WAIT_SS: hold until SS_n returns high
      endcase
    end
  end

  // State registers; reset inside a frame parks the FSM until SS_n rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SS_n ? ST_IDLE : ST_WAIT_SS;
      cnt_q     <= '0;
      ptr_q     <= '0;
      addr_sh_q <= '0;
      dat_sh_q  <= '0;
      wdata_q   <= '0;
      op_q      <= 1'b0;
      rd_q      <= 1'b0;
      we_q      <= 1'b0;
      miso_q    <= 1'b0;
      err_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      addr_sh_q <= addr_sh_d;
      dat_sh_q  <= dat_sh_d;
      wdata_q   <= wdata_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
      miso_q    <= miso_d;
      err_q     <= err_d;
      ferr_q    <= ferr_d;
    end
  end

endmodule

// File: tb/tb_spi_ram_burst_top.sv
// Bench for spi_ram_burst_top: a default instance (256 words) and a
// DEPTH=200 instance share clock and reset; each frame is compared edge by
// edge against a word-level memory model.
module tb_spi_ram_burst_top;
  import spi_ram_pkg::*;

  localparam int DW = 8;
  localparam int AW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic ss_n0 = 1'b1, mosi0 = 1'b0, miso0, ferr0;
  logic ss_n1 = 1'b1, mosi1 = 1'b0, miso1, ferr1;

  spi_ram_burst_top u_dut0 (
    .clk(clk), .rst(rst), .SS_n(ss_n0), .MOSI(mosi0), .MISO(miso0), .frame_err(ferr0)
  );

  spi_ram_burst_top #(.DATA_W(8), .ADDR_W(8), .DEPTH(200)) u_dut1 (
    .clk(clk), .rst(rst), .SS_n(ss_n1), .MOSI(mosi1), .MISO(miso1), .frame_err(ferr1)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] ref_mem [2][256];
  logic [DW-1:0] wq[$];          // words offered on the wire for a write
  logic [DW-1:0] exp_q[$];       // expected read words for table rows
  logic drv_ss[$], drv_mosi[$], drv_rst[$];
  logic cap_miso[$], cap_ferr[$];
  logic exp_miso[$], exp_ferr[$];

  typedef struct {
    int            d;
    logic [1:0]    op;
    int            addr;
    int            nw;
    int            extra;
    logic [DW-1:0] w0, w1;
    bit            exp_err;
    logic [DW-1:0] r0, r1;
  } vec_t;

  vec_t tbl[16];

  function automatic int depth_of(input int d);
    return (d == 0) ? 256 : 200;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_edge(input logic ss, input logic mo, input logic r);
    drv_ss.push_back(ss);
    drv_mosi.push_back(mo);
    drv_rst.push_back(r);
  endtask

  // Plays the drive queues, one clock edge per entry; cap[i] holds the
  // outputs as they stand after edge i.
  task automatic apply(input int d);
    cap_miso.delete();
    cap_ferr.delete();
    for (int i = 0; i < drv_ss.size(); i++) begin
      rst = drv_rst[i];
      if (d == 0) begin ss_n0 = drv_ss[i]; mosi0 = drv_mosi[i]; end
      else        begin ss_n1 = drv_ss[i]; mosi1 = drv_mosi[i]; end
      @(posedge clk);
      @(negedge clk);
      cap_miso.push_back((d == 0) ? miso0 : miso1);
      cap_ferr.push_back((d == 0) ? ferr0 : ferr1);
    end
    rst = 1'b0;
    ss_n0 = 1'b1; ss_n1 = 1'b1; mosi0 = 1'b0; mosi1 = 1'b0;
    drv_ss.delete(); drv_mosi.delete(); drv_rst.delete();
  endtask

  // ---------------- reference model ----------------
  task automatic expect_quiet(input int n);
    exp_miso.delete();
    exp_ferr.delete();
    for (int k = 0; k < n; k++) begin
      exp_miso.push_back(1'b0);
      exp_ferr.push_back(1'b0);
    end
  endtask

  // Frame edges 0..L-1 have SS_n low, followed by 4 edges with SS_n high.
  task automatic model_frame(input int d, input logic [1:0] op, input int addr,
                             input int nw, input int extra);
    int dep = depth_of(d);
    int L = 2 + AW + ((op == OP_RD) ? 1 : 0) + nw * DW + extra;
    expect_quiet(L + 4);
    if (op != OP_WR && op != OP_RD) begin
      exp_ferr[2] = 1'b1;                       // edge after opcode bit 1
    end else if (addr >= dep) begin
      exp_ferr[AW + 2] = 1'b1;                  // edge after last address bit
    end else if (op == OP_WR) begin
      for (int j = 0; j < nw; j++) ref_mem[d][(addr + j) % dep] = wq[j];
      if (extra > 0) exp_ferr[L + 1] = 1'b1;    // edge after SS_n rose
    end else begin
      for (int k = AW + 3; k < L; k++) begin
        int i;
        logic [DW-1:0] w;
        i = k - (AW + 3);
        w = ref_mem[d][(addr + i / DW) % dep];
        exp_miso[k] = w[DW - 1 - (i % DW)];
      end
    end
  endtask

  // ---------------- checks ----------------
  task automatic check_stream(input string nm);
    int bad_m = -1;
    int bad_f = -1;
    n_checks += 2;
    if (cap_miso.size() != exp_miso.size()) begin
      n_fail += 2;
      $display("FAIL %s length: got %0d edges, expected %0d", nm, cap_miso.size(), exp_miso.size());
    end else begin
      for (int i = 0; i < exp_miso.size(); i++) begin
        if (bad_m < 0 && cap_miso[i] !== exp_miso[i]) bad_m = i;
        if (bad_f < 0 && cap_ferr[i] !== exp_ferr[i]) bad_f = i;
      end
      if (bad_m >= 0) begin
        n_fail++;
        $display("FAIL %s MISO: edge %0d got %b expected %b", nm, bad_m, cap_miso[bad_m], exp_miso[bad_m]);
      end
      if (bad_f >= 0) begin
        n_fail++;
        $display("FAIL %s frame_err: edge %0d got %b expected %b", nm, bad_f, cap_ferr[bad_f], exp_ferr[bad_f]);
      end
    end
  endtask

  // Reassembles read words from MISO and compares them with exp_q.
  task automatic check_words(input string nm, input int nw, input int extra);
    for (int j = 0; j < nw + ((extra > 0) ? 1 : 0); j++) begin
      int nb;
      int base;
      logic [DW-1:0] got, want;
      nb   = (j < nw) ? DW : extra;
      base = AW + 3 + j * DW;
      got  = '0;
      want = exp_q.pop_front();
      for (int b = 0; b < DW; b++) begin
        if (b < nb) got[DW-1-b] = (base + b < cap_miso.size()) ? cap_miso[base + b] : 1'bx;
        else        want[DW-1-b] = 1'b0;
      end
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s word %0d: got %h expected %h (%0d bits)", nm, j, got, want, nb);
      end
    end
  endtask

  task automatic check_err_count(input string nm, input bit exp_err);
    int pulses = 0;
    foreach (cap_ferr[i]) if (cap_ferr[i] === 1'b1) pulses++;
    n_checks++;
    if (pulses != (exp_err ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s err pulses: got %0d expected %0d", nm, pulses, exp_err ? 1 : 0);
    end
  endtask

  // Builds the MOSI bit stream for one frame, runs it, checks against the model.
  task automatic frame(input int d, input logic [1:0] op, input int addr,
                       input int nw, input int extra, input string nm);
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    a = AW'(addr);
    push_edge(1'b0, op[1], 1'b0);
    push_edge(1'b0, op[0], 1'b0);
    for (int b = AW - 1; b >= 0; b--) push_edge(1'b0, a[b], 1'b0);
    if (op == OP_RD) push_edge(1'b0, 1'($urandom), 1'b0);
    for (int i = 0; i < nw * DW + extra; i++) begin
      if (op == OP_WR && (i / DW) < wq.size()) w = wq[i / DW];
      else                                       w = DW'($urandom);
      push_edge(1'b0, w[DW - 1 - (i % DW)], 1'b0);
    end
    for (int i = 0; i < 4; i++) push_edge(1'b1, 1'b0, 1'b0);
    model_frame(d, op, addr, nw, extra);
    apply(d);
    check_stream(nm);
  endtask

  // Write header plus the first nbits of word w, all with SS_n low.
  task automatic push_wr_head(input int addr, input logic [DW-1:0] w, input int nbits);
    logic [AW-1:0] a;
    a = AW'(addr);
    push_edge(1'b0, 1'b0, 1'b0);
    push_edge(1'b0, 1'b0, 1'b0);
    for (int b = AW - 1; b >= 0; b--) push_edge(1'b0, a[b], 1'b0);
    for (int b = 0; b < nbits; b++) push_edge(1'b0, w[DW - 1 - b], 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks += 4;
    if (miso0 !== 1'b0) begin n_fail++; $display("FAIL reset miso0: got %b expected 0", miso0); end
    if (ferr0 !== 1'b0) begin n_fail++; $display("FAIL reset ferr0: got %b expected 0", ferr0); end
    if (miso1 !== 1'b0) begin n_fail++; $display("FAIL reset miso1: got %b expected 0", miso1); end
    if (ferr1 !== 1'b0) begin n_fail++; $display("FAIL reset ferr1: got %b expected 0", ferr1); end
    rst = 1'b0;
    @(negedge clk);

    // Give both RAMs known contents with one full-depth burst each.
    for (int d = 0; d < 2; d++) begin
      wq.delete();
      for (int i = 0; i < depth_of(d); i++) wq.push_back(DW'($urandom));
      frame(d, OP_WR, 0, depth_of(d), 0, "fill");
    end

    // Table: d, op, addr, nw, extra, w0, w1, exp_err, r0, r1
    tbl[0]  = '{0, OP_WR, 'h10, 2, 0, 8'hA5, 8'h3C, 1'b0, 8'h00, 8'h00};
    tbl[1]  = '{0, OP_RD, 'h10, 2, 0, 8'h00, 8'h00, 1'b0, 8'hA5, 8'h3C};
    tbl[2]  = '{0, OP_WR, 'hFF, 2, 0, 8'h11, 8'h22, 1'b0, 8'h00, 8'h00};
    tbl[3]  = '{0, OP_RD, 'hFF, 2, 0, 8'h00, 8'h00, 1'b0, 8'h11, 8'h22};
    tbl[4]  = '{0, OP_RD, 'h00, 1, 0, 8'h00, 8'h00, 1'b0, 8'h22, 8'h00};
    tbl[5]  = '{0, OP_WR, 'h21, 1, 0, 8'h99, 8'h00, 1'b0, 8'h00, 8'h00};
    tbl[6]  = '{0, OP_WR, 'h20, 1, 4, 8'h55, 8'hA0, 1'b1, 8'h00, 8'h00};
    tbl[7]  = '{0, OP_RD, 'h20, 2, 0, 8'h00, 8'h00, 1'b0, 8'h55, 8'h99};
    tbl[8]  = '{0, 2'b11, 'h10, 1, 4, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00};
    tbl[9]  = '{0, 2'b10, 'h10, 2, 0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00};
    tbl[10] = '{0, OP_RD, 'h10, 1, 3, 8'h00, 8'h00, 1'b0, 8'hA5, 8'h3C};
    tbl[11] = '{1, OP_WR, 'hC7, 2, 0, 8'h77, 8'h88, 1'b0, 8'h00, 8'h00};
    tbl[12] = '{1, OP_RD, 'hC7, 2, 0, 8'h00, 8'h00, 1'b0, 8'h77, 8'h88};
    tbl[13] = '{1, OP_RD, 'hF0, 1, 0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00};
    tbl[14] = '{1, OP_WR, 'hC8, 1, 0, 8'hAB, 8'h00, 1'b1, 8'h00, 8'h00};
    tbl[15] = '{1, OP_RD, 'h00, 1, 0, 8'h00, 8'h00, 1'b0, 8'h88, 8'h00};

    for (int t = 0; t < 16; t++) begin
      string nm;
      nm = $sformatf("vec%0d", t);
      wq.delete();
      wq.push_back(tbl[t].w0);
      wq.push_back(tbl[t].w1);
      frame(tbl[t].d, tbl[t].op, tbl[t].addr, tbl[t].nw, tbl[t].extra, nm);
      check_err_count(nm, tbl[t].exp_err);
      if (tbl[t].op == OP_RD) begin
        exp_q.delete();
        exp_q.push_back(tbl[t].r0);
        exp_q.push_back(tbl[t].r1);
        check_words(nm, tbl[t].nw, tbl[t].extra);
      end
    end

    // Reset for one cycle in the middle of a write word, SS_n held low.
    wq.delete(); wq.push_back(8'hEE); wq.push_back(8'hDD);
    frame(0, OP_WR, 'h40, 2, 0, "pre40");
    push_wr_head('h40, 8'hF0, 4);
    push_edge(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) push_edge(1'b0, 1'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) push_edge(1'b1, 1'b0, 1'b0);
    expect_quiet(drv_ss.size());
    apply(0);
    check_stream("rst_mid_word");
    frame(0, OP_RD, 'h40, 2, 0, "rd40");
    exp_q.delete(); exp_q.push_back(8'hEE); exp_q.push_back(8'hDD);
    check_words("rd40", 2, 0);

    // Reset on the very edge that would write a completed word.
    wq.delete(); wq.push_back(8'h12);
    frame(0, OP_WR, 'h50, 1, 0, "pre50");
    push_wr_head('h50, 8'h6B, DW);
    push_edge(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) push_edge(1'b1, 1'b0, 1'b0);
    expect_quiet(drv_ss.size());
    apply(0);
    check_stream("rst_on_write");
    frame(0, OP_RD, 'h50, 1, 0, "rd50");
    exp_q.delete(); exp_q.push_back(8'h12);
    check_words("rd50", 1, 0);

    // Randomized frames against the model.
    for (int n = 0; n < 60; n++) begin
      int d, r, addr, nw, extra;
      logic [1:0] op;
      d     = n % 2;
      r     = $urandom_range(0, 9);
      op    = (r < 5) ? OP_WR : (r < 9) ? OP_RD : 2'b11;
      addr  = $urandom_range(0, 255);
      nw    = $urandom_range(1, 3);
      extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DW - 1) : 0;
      wq.delete();
      for (int i = 0; i <= nw; i++) wq.push_back(DW'($urandom));
      frame(d, op, addr, nw, extra, $sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_ram_burst_top.md
# spi_ram_burst_top

Parametrised successor to the SPI-slave-plus-RAM top level: a single-clock SPI slave with an internal single-port synchronous RAM. It adds configurable data/address width and depth, multi-word burst write and burst read with auto-incrementing, wrapping address, and a frame-error pulse. It replaces the fixed 10-bit-frame SPI/RAM pair as the memory-mapped endpoint behind an SPI master.

## Interface
- `DATA_W`, default 8, bits per RAM word and per SPI data word.
- `ADDR_W`, default 8, address bits sent on the wire.
- `DEPTH`, default 2**ADDR_W, number of RAM words; must be ≤ 2**ADDR_W.

Ports:
- `clk` input 1: single clock, also the SPI bit clock; all sampling on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `SS_n` input 1: active-low slave select; a frame is a contiguous run of SS_n=0 cycles.
- `MOSI` input 1: serial data from master, MSB first, sampled on rising clk while SS_n=0.
- `MISO` output 1: registered serial data to master, MSB first.
- `frame_err` output 1: one-cycle pulse flagging a malformed frame.

## Operation
- Frame bit index n counts rising edges with SS_n=0, starting at n=0 on the first such edge.
- n=0..1: opcode, MSB first. `00` = burst write, `01` = burst read, `10` and `11` = reserved.
- n=2..ADDR_W+1: start address, MSB first, loaded into the address pointer `ptr`.
- Burst write: each following group of DATA_W bits is one word.
  - The word is written to RAM[ptr] on the edge after its last bit, even if SS_n rises on that edge.
  - `ptr` then increments.
- Burst read:
  - n=ADDR_W+2 is the turnaround cycle: the RAM read of RAM[ptr] is issued and MISO stays 0.
  - Words are then shifted out MSB first, back to back.
  - The next word, RAM[ptr+1], is fetched during the last bit of the current word, so there is no gap between words.
  - MOSI is ignored during a read.
- Address wrap: `ptr` increments modulo DEPTH (DEPTH-1 → 0).
- Out-of-range start address (≥ DEPTH): frame_err pulses, and the frame is ignored until SS_n returns high.
- Reserved opcode: frame_err pulses on the edge after n=1; state goes to IGNORE.
- Truncated write word (SS_n rises mid-word): the partial word is discarded, nothing is written, and frame_err pulses once.
  - A truncated read is not an error.
- SS_n high at any point:
  - Next state is IDLE.
  - MISO = 0 from the next edge.
  - All in-flight shift registers are cleared.
- States: IDLE, OPCODE, ADDR, WR_DATA, RD_TURN, RD_DATA, IGNORE, WAIT_SS.
  - IDLE→OPCODE: on the first SS_n=0 edge.
  - OPCODE→ADDR / IGNORE: by opcode.
  - ADDR→WR_DATA / RD_TURN / IGNORE: by opcode and range check.
  - RD_TURN→RD_DATA.
  - Any state→IDLE: when SS_n=1, except WAIT_SS.
  - WAIT_SS→IDLE: only after seeing SS_n=1.
- Reset:
  - State goes to WAIT_SS if SS_n=0, else IDLE.
  - MISO=0, frame_err=0, ptr=0, shift registers=0.
  - RAM contents are not cleared.
  - Reset mid-frame aborts the frame with no RAM write, and the rest of that frame is ignored.
- Simultaneous rst and a word-complete write edge: rst wins, no write.

## Timing
- MISO and frame_err are registered and change only on rising clk.
- Read data placement:
  - Word j bit b (b=DATA_W-1 down to 0) is driven from edge ADDR_W+3 + j·DATA_W + (DATA_W-1-b).
  - So the first data bit appears 2 edges after the last address bit.
- Write latency: a word is visible to a same-address read in any later frame; the RAM write completes 1 edge after the word's last bit.
- RAM: single-port, synchronous read with 1-cycle latency, write-first not required. Reads and writes never coincide within one frame.
- Minimum SS_n high gap between frames: 1 cycle.

## Structure
- Package `spi_ram_pkg` contains:
  - opcode constants `OP_WR=2'b00`, `OP_RD=2'b01`;
  - the state enum type;
  - the DEPTH-vs-ADDR_W legality check function.
- Sub-module `spi_ram_sp_mem`: parametrised single-port synchronous RAM (`DATA_W`, `DEPTH`; ports `clk`, `we`, `addr`, `din`, `dout`), with no reset on the array, so it infers block RAM.
- The top level holds the FSM, bit counter, address pointer and shift registers.

## Test plan
- Defaults. Write frame `00`, addr 0x10, data 0xA5, 0x3C. Then read frame `01`, addr 0x10, held for 2 words. MISO = turnaround 0, then 0xA5 then 0x3C, MSB first, with no gap.
- Wrap. Write addr 0xFF, data 0x11, 0x22. Read from 0xFF, 2 words. Returns 0x11 then 0x22, and RAM[0x00] = 0x22.
- Truncated write. Write addr 0x20, data 0x55, then SS_n rises after 4 bits of the next word. frame_err pulses once. RAM[0x20] = 0x55 and RAM[0x21] is unchanged.
- Reserved opcode `11`, followed by 20 cycles of MOSI activity. frame_err pulses on the edge after n=1. MISO stays 0 and no RAM changes.
- rst asserted for 1 cycle mid-write-word with SS_n held low. No write occurs, the remainder of the frame is ignored, and the next frame after SS_n high operates normally.
- DEPTH=200, ADDR_W=8. A read from addr 0xF0 gives frame_err and MISO=0. A read from 0xC7 wraps to 0x00 after the first word.
